bbqm_sensor_cond: RTL and testbench

BBQM_SENSOR_COND -- requirements
Module: bbqm_sensor_cond

---
 rtl/bbqm_pkg.sv | 21 ++
 rtl/bbqm_debounce.sv | 51 +++++
 rtl/bbqm_sensor_cond.sv | 126 ++++++++++++
 tb/tb_bbqm_sensor_cond.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bbqm_pkg.sv
// Shared definitions for the queue-counter sensor conditioning block:
// FSM state encoding, parameter defaults and pending-counter width.
package bbqm_pkg;

  // 10 ms of stable input at 50 MHz before a new level is accepted.
  localparam int unsigned DB_CYCLES_DEF = 500000;

  // Saturation value of each pending-event counter.
  localparam int unsigned PEND_MAX_DEF = 3;

  // Width of the pending-event counters.
  localparam int unsigned PEND_W = 2;

  // Request FSM: one state per kind of outstanding request.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INC  = 2'd1,
    DEC  = 2'd2
  } bbqm_state_e;

endpackage

// File: rtl/bbqm_debounce.sv
// One sensor channel: two-flop synchronizer, debounce counter, debounced
// level and a one-cycle strobe on each accepted rising level.
module bbqm_debounce
  import bbqm_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sens,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DB_CYCLES);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous photocell into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], sens};
    end
  end

  // Count cycles the synchronized input disagrees with the accepted level;
  // flip the level once the disagreement has lasted DB_CYCLES counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_TOP) begin
        cnt   <= '0;
        level <= ~level;
        rise  <= ~level;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bbqm_sensor_cond.sv
// Sensor conditioning for the queue person counter: debounces the arrival
// and departure photocells, buffers their rising edges as pending events
// and presents them one at a time as increment/decrement requests.
//
// Request/acknowledge: inc_req or dec_req is a level that stays high until
// evt_ack is sampled high on a rising clk edge while it is asserted; that
// edge completes the transfer and consumes one pending event. The request
// then drops for at least one cycle before the next one is raised.
// evt_ack while no request is raised has no effect.
module bbqm_sensor_cond
  import bbqm_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned PEND_MAX  = PEND_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sens_arr,
  input  logic              sens_dep,
  input  logic              evt_ack,
  output logic              inc_req,
  output logic              dec_req,
  output logic              arr_db,
  output logic              dep_db,
  output logic [PEND_W-1:0] pend_arr,
  output logic [PEND_W-1:0] pend_dep,
  output logic              ovf,
  output bbqm_state_e       fsm_state
);

  localparam logic [PEND_W-1:0] PEND_TOP = PEND_W'(PEND_MAX);

  bbqm_state_e       state;
  bbqm_state_e       state_nxt;
  logic              arr_rise;
  logic              dep_rise;
  logic              arr_ack;
  logic              dep_ack;
  logic [PEND_W-1:0] arr_nxt;
  logic [PEND_W-1:0] dep_nxt;
  logic              lost;

  bbqm_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_arr (
    .clk   (clk),
    .reset (reset),
    .sens  (sens_arr),
    .level (arr_db),
    .rise  (arr_rise)
  );

  bbqm_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dep (
    .clk   (clk),
    .reset (reset),
    .sens  (sens_dep),
    .level (dep_db),
    .rise  (dep_rise)
  );

  // An acknowledge only counts against the channel currently requested.
  assign arr_ack   = (state == INC) && evt_ack;
  assign dep_ack   = (state == DEC) && evt_ack;
  assign fsm_state = state;

  // Next pending counts: event adds, acknowledge removes, both cancel out;
  // an event arriving at a full counter is dropped and flagged.
  always_comb begin
    arr_nxt = pend_arr;
    dep_nxt = pend_dep;
    lost    = 1'b0;
    if (arr_rise && !arr_ack) begin
      if (pend_arr == PEND_TOP) lost = 1'b1;
      else                      arr_nxt = pend_arr + PEND_W'(1);
    end else if (!arr_rise && arr_ack) begin
      arr_nxt = pend_arr - PEND_W'(1);
    end
    if (dep_rise && !dep_ack) begin
      if (pend_dep == PEND_TOP) lost = 1'b1;
      else                      dep_nxt = pend_dep + PEND_W'(1);
    end else if (!dep_rise && dep_ack) begin
      dep_nxt = pend_dep - PEND_W'(1);
    end
  end

  // Pending counters and the sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_arr <= '0;
      pend_dep <= '0;
      ovf      <= 1'b0;
    end else begin
      pend_arr <= arr_nxt;
      pend_dep <= dep_nxt;
      if (lost) ovf <= 1'b1;
    end
  end

  // Request FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and Moore request outputs; departures are served first so
  // the count never lags behind people leaving.
  always_comb begin
    state_nxt = state;
    inc_req   = 1'b0;
    dec_req   = 1'b0;
    case (state)
      IDLE: begin
        if (pend_dep != '0)      state_nxt = DEC;
        else if (pend_arr != '0) state_nxt = INC;
      end
      INC: begin
        inc_req = 1'b1;
        if (evt_ack) state_nxt = IDLE;
      end
      DEC: begin
        dec_req = 1'b1;
        if (evt_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bbqm_sensor_cond.sv
// Bench for bbqm_sensor_cond with a short debounce window.
module tb_bbqm_sensor_cond;
  import bbqm_pkg::*;

  localparam int DB   = 4;
  localparam int PMAX = 3;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        sens_arr = 1'b0;
  logic        sens_dep = 1'b0;
  logic        evt_ack  = 1'b0;
  logic        inc_req;
  logic        dec_req;
  logic        arr_db;
  logic        dep_db;
  logic [1:0]  pend_arr;
  logic [1:0]  pend_dep;
  logic        ovf;
  bbqm_state_e fsm_state;

  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  bbqm_sensor_cond #(.DB_CYCLES(DB), .PEND_MAX(PMAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .sens_arr  (sens_arr),
    .sens_dep  (sens_dep),
    .evt_ack   (evt_ack),
    .inc_req   (inc_req),
    .dec_req   (dec_req),
    .arr_db    (arr_db),
    .dep_db    (dep_db),
    .pend_arr  (pend_arr),
    .pend_dep  (pend_dep),
    .ovf       (ovf),
    .fsm_state (fsm_state)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, confirm outputs clear without a clock edge,
  // release on a falling edge so the next rising edge is edge 0.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset    = 1'b0;
    sens_arr = 1'b0;
    sens_dep = 1'b0;
    evt_ack  = 1'b0;
    #1;
    check("rst_inc", inc_req, 0);
    check("rst_dec", dec_req, 0);
    check("rst_pend", {pend_arr, pend_dep}, 0);
    check("rst_db", {arr_db, dep_db}, 0);
    check("rst_ovf", ovf, 0);
    check("rst_state", int'(fsm_state), int'(IDLE));
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic       sa;
    logic       sd;
    logic       ack;
    int         reps;
    logic [8:0] exp; // {arr_db, dep_db, pend_arr, pend_dep, inc, dec, ovf}
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic sa, input logic sd, input logic ack,
                              input int reps, input logic adb, input logic ddb,
                              input int pa, input int pd, input logic inc,
                              input logic dec, input logic ov);
    vec_t v;
    v.sa   = sa;
    v.sd   = sd;
    v.ack  = ack;
    v.reps = reps;
    v.exp  = {adb, ddb, 2'(pa), 2'(pd), inc, dec, ov};
    vt.push_back(v);
  endfunction

  function automatic logic [8:0] dut_vec();
    return {arr_db, dep_db, pend_arr, pend_dep, inc_req, dec_req, ovf};
  endfunction

  // ---------------- behavioural reference model ----------------
  // Accepted level flips once the raw input, as seen two samples late,
  // has disagreed with it for DB+1 consecutive samples.
  logic ha[$];
  logic hd[$];
  logic m_adb, m_ddb;
  int   m_ra, m_rd, m_pa, m_pd, m_ovf, m_req; // m_req: 0 none, 1 inc, 2 dec
  logic [8:0] exp_q[$];

  function automatic void model_reset();
    ha.delete();
    hd.delete();
    for (int i = 0; i < DB + 2; i++) begin
      ha.push_back(1'b0);
      hd.push_back(1'b0);
    end
    m_adb = 1'b0; m_ddb = 1'b0;
    m_ra = 0; m_rd = 0; m_pa = 0; m_pd = 0; m_ovf = 0; m_req = 0;
  endfunction

  function automatic bit window_opposes(input bit ch, input logic lvl);
    for (int k = 2; k <= DB + 2; k++) begin
      if ((ch ? hd[hd.size() - 1 - k] : ha[ha.size() - 1 - k]) == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_edge(input logic sa, input logic sd, input logic ack);
    int ack_a;
    int ack_d;
    int nreq;
    ack_a = (m_req == 1 && ack) ? 1 : 0;
    ack_d = (m_req == 2 && ack) ? 1 : 0;
    if (m_req != 0)    nreq = ack ? 0 : m_req;
    else if (m_pd > 0) nreq = 2;
    else if (m_pa > 0) nreq = 1;
    else               nreq = 0;
    m_pa = m_pa + m_ra - ack_a;
    if (m_pa > PMAX) begin m_pa = PMAX; m_ovf = 1; end
    m_pd = m_pd + m_rd - ack_d;
    if (m_pd > PMAX) begin m_pd = PMAX; m_ovf = 1; end
    m_req = nreq;
    ha.push_back(sa);
    hd.push_back(sd);
    m_ra = 0;
    m_rd = 0;
    if (window_opposes(1'b0, m_adb)) begin m_adb = ~m_adb; m_ra = int'(m_adb); end
    if (window_opposes(1'b1, m_ddb)) begin m_ddb = ~m_ddb; m_rd = int'(m_ddb); end
    while (ha.size() > DB + 3) void'(ha.pop_front());
    while (hd.size() > DB + 3) void'(hd.pop_front());
  endfunction

  function automatic logic [8:0] model_vec();
    return {m_adb, m_ddb, 2'(m_pa), 2'(m_pd), m_req == 1, m_req == 2, m_ovf[0]};
  endfunction

  // ---------------- test sequence ----------------
  int         hs;
  int         w;
  int         a_left;
  int         d_left;
  int         ack_div;
  logic [8:0] got;
  logic [8:0] exp;

  initial begin
    // Arrival accepted, request held, acknowledged; falling edge silent;
    // short departure glitch rejected; ack in IDLE ignored.
    add(1,0,0,6, 0,0,0,0,0,0,0);
    add(1,0,0,1, 1,0,0,0,0,0,0);
    add(1,0,0,1, 1,0,1,0,0,0,0);
    add(1,0,0,3, 1,0,1,0,1,0,0);
    add(1,0,1,1, 1,0,0,0,0,0,0);
    add(1,0,0,1, 1,0,0,0,0,0,0);
    add(0,0,0,6, 1,0,0,0,0,0,0);
    add(0,0,0,3, 0,0,0,0,0,0,0);
    add(0,1,0,3, 0,0,0,0,0,0,0);
    add(0,0,0,8, 0,0,0,0,0,0,0);
    add(0,0,1,2, 0,0,0,0,0,0,0);
    // Simultaneous arrival and departure: departure served first, one
    // IDLE cycle, then the arrival.
    add(1,1,0,6, 0,0,0,0,0,0,0);
    add(1,1,0,1, 1,1,0,0,0,0,0);
    add(1,1,0,1, 1,1,1,1,0,0,0);
    add(1,1,1,1, 1,1,1,1,0,1,0);
    add(1,1,0,1, 1,1,1,1,0,1,0);
    add(1,1,1,1, 1,1,1,0,0,0,0);
    add(1,1,0,1, 1,1,1,0,1,0,0);
    add(1,1,1,1, 1,1,0,0,0,0,0);
    add(1,1,0,2, 1,1,0,0,0,0,0);

    do_reset();
    foreach (vt[i]) begin
      for (int r = 0; r < vt[i].reps; r++) begin
        sens_arr = vt[i].sa;
        sens_dep = vt[i].sd;
        evt_ack  = vt[i].ack;
        tick();
        got = dut_vec();
        checks++;
        if (got !== vt[i].exp) begin
          errors++;
          $display("FAIL tv%0d_r%0d: got %b expected %b", i, r, got, vt[i].exp);
        end
      end
    end
    evt_ack = 1'b0;

    // Saturation: five arrivals with no acknowledge.
    do_reset();
    for (int n = 0; n < 5; n++) begin
      sens_arr = 1'b1; repeat (8) tick();
      sens_arr = 1'b0; repeat (8) tick();
    end
    check("sat_pend", pend_arr, 3);
    check("sat_ovf", ovf, 1);
    check("sat_inc", inc_req, 1);
    hs = 0;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      while (!inc_req && w < 12) begin tick(); w++; end
      if (inc_req) begin
        evt_ack = 1'b1; tick(); evt_ack = 1'b0;
        hs++;
      end
    end
    check("sat_handshakes", hs, 3);
    check("sat_pend_end", pend_arr, 0);
    check("sat_ovf_sticky", ovf, 1);

    // Event coinciding with acknowledge of the previous arrival.
    do_reset();
    sens_arr = 1'b1; repeat (9) tick();
    check("co_inc1", inc_req, 1);
    check("co_pend1", pend_arr, 1);
    sens_arr = 1'b0; repeat (7) tick();
    check("co_fall", arr_db, 0);
    sens_arr = 1'b1; repeat (7) tick();
    check("co_rise", arr_db, 1);
    check("co_pend_pre", pend_arr, 1);
    evt_ack = 1'b1; tick(); evt_ack = 1'b0;
    check("co_pend_hold", pend_arr, 1);
    check("co_idle_gap", inc_req, 0);
    tick();
    check("co_inc2", inc_req, 1);
    evt_ack = 1'b1; tick(); evt_ack = 1'b0;
    check("co_pend_end", pend_arr, 0);
    check("co_inc_end", inc_req, 0);

    // Reset while a request is held with two events pending.
    do_reset();
    sens_arr = 1'b1; repeat (8) tick();
    sens_arr = 1'b0; repeat (8) tick();
    sens_arr = 1'b1; repeat (8) tick();
    check("hr_pend2", pend_arr, 2);
    check("hr_inc", inc_req, 1);
    #2;
    reset = 1'b0;
    #1;
    check("hr_inc_async", inc_req, 0);
    check("hr_pend_async", pend_arr, 0);
    check("hr_ovf_async", ovf, 0);
    check("hr_db_async", arr_db, 0);
    sens_arr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("hr_quiet_req", {inc_req, dec_req}, 0);
      check("hr_quiet_pend", pend_arr, 0);
    end
    check("hr_state", int'(fsm_state), int'(IDLE));

    // Randomized traffic against the reference model: frequent acks,
    // then rare acks so counters saturate.
    for (int phase = 0; phase < 2; phase++) begin
      do_reset();
      model_reset();
      a_left  = 0;
      d_left  = 0;
      ack_div = (phase == 0) ? 2 : 8;
      for (int c = 0; c < 1500; c++) begin
        if (a_left == 0) begin
          sens_arr = 1'($urandom_range(0, 1));
          a_left   = $urandom_range(1, 12);
        end
        if (d_left == 0) begin
          sens_dep = 1'($urandom_range(0, 1));
          d_left   = $urandom_range(1, 12);
        end
        a_left--;
        d_left--;
        evt_ack = ($urandom_range(0, ack_div - 1) == 0);
        model_edge(sens_arr, sens_dep, evt_ack);
        exp_q.push_back(model_vec());
        tick();
        got = dut_vec();
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL rnd_p%0d_c%0d: got %b expected %b", phase, c, got, exp);
        end
        check("rnd_excl", int'(inc_req & dec_req), 0);
      end
    end
    evt_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
